instr_seq: RTL

INSTR_SEQ -- requirements
Module: instr_seq

---
 rtl/npc_pkg.sv | 27 ++
 rtl/seq_watchdog.sv | 34 +++
 rtl/instr_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: shared sequencer state encoding, state width and halt reason codes.
package npc_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_HALT   = 3'd7
    } seq_state_e;

    localparam logic [2:0] HALT_NONE    = 3'd0;
    localparam logic [2:0] HALT_EBREAK  = 3'd1;
    localparam logic [2:0] HALT_ILLEGAL = 3'd2;
    localparam logic [2:0] HALT_BUSERR  = 3'd3;
    localparam logic [2:0] HALT_TIMEOUT = 3'd4;

    function automatic logic is_wait_state(seq_state_e s);
        return (s == S_FETCH) || (s == S_MEM);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: counts consecutive cycles spent waiting on a bus handshake and
// flags expiry on the cycle the count reaches TIMEOUT_CYCLES.
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle outside a wait state clears the count, so entry always starts at zero.
    always_comb begin
        cnt_d = '0;
        if (wait_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = wait_i && (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instr_seq.sv
// instr_seq: multi-cycle fetch/decode/execute sequencer driving the core datapath strobes.
// Define SEQ_TIMEOUT_EN to bound bus handshakes through the seq_watchdog sub-module.
module instr_seq
    import npc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req,
    input  logic        ifu_rvalid,
    input  logic        ifu_err,
    output logic        inst_we,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_reg_write,
    input  logic        dec_ebreak,
    input  logic        dec_ecall,
    input  logic        dec_illegal,
    output logic        lsu_req,
    input  logic        lsu_done,
    input  logic        lsu_err,
    output logic        rf_we,
    output logic        pc_we,
    output logic        trap_sel,
    output logic        csr_trap_we,
    output logic        halt,
    output logic [2:0]  halt_code,
    output logic [2:0]  state_o,
    output logic [31:0] instret
);

    seq_state_e  state_q, state_d;
    logic [2:0]  halt_code_q, halt_code_d;
    logic [31:0] instret_q;
    logic        ifu_req_q, lsu_req_q, rf_we_q, pc_we_q;
    logic        trap_sel_q, csr_trap_we_q, halt_q;
    logic        timeout_hit;

`ifdef SEQ_TIMEOUT_EN
    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .wait_i   (is_wait_state(state_q)),
        .expired_o(timeout_hit)
    );
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    // Bus errors beat responses, and a response beats a watchdog expiry in the same cycle.
    always_comb begin
        state_d     = state_q;
        halt_code_d = halt_code_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (ifu_err) begin
                    state_d     = S_HALT;
                    halt_code_d = HALT_BUSERR;
                end else if (ifu_rvalid) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d     = S_HALT;
                    halt_code_d = HALT_TIMEOUT;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (dec_illegal) begin
                    state_d     = S_HALT;
                    halt_code_d = HALT_ILLEGAL;
                end else if (dec_ebreak) begin
                    state_d     = S_HALT;
                    halt_code_d = HALT_EBREAK;
                end else if (dec_ecall) begin
                    state_d = S_TRAP;
                end else if (dec_mem_read || dec_mem_write) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (lsu_err) begin
                    state_d     = S_HALT;
                    halt_code_d = HALT_BUSERR;
                end else if (lsu_done) begin
                    state_d = S_WB;
                end else if (timeout_hit) begin
                    state_d     = S_HALT;
                    halt_code_d = HALT_TIMEOUT;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // Strobes are registered from the next state so each one is a clean Moore output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            halt_code_q   <= HALT_NONE;
            instret_q     <= 32'd0;
            ifu_req_q     <= 1'b0;
            lsu_req_q     <= 1'b0;
            rf_we_q       <= 1'b0;
            pc_we_q       <= 1'b0;
            trap_sel_q    <= 1'b0;
            csr_trap_we_q <= 1'b0;
            halt_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            halt_code_q   <= halt_code_d;
            ifu_req_q     <= (state_d == S_FETCH);
            lsu_req_q     <= (state_d == S_MEM);
            rf_we_q       <= (state_d == S_WB) && dec_reg_write && !dec_mem_write;
            pc_we_q       <= (state_d == S_WB) || (state_d == S_TRAP);
            trap_sel_q    <= (state_d == S_TRAP);
            csr_trap_we_q <= (state_d == S_TRAP);
            halt_q        <= (state_d == S_HALT);
            if (state_q == S_WB) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign ifu_req     = ifu_req_q;
    assign lsu_req     = lsu_req_q;
    assign rf_we       = rf_we_q;
    assign pc_we       = pc_we_q;
    assign trap_sel    = trap_sel_q;
    assign csr_trap_we = csr_trap_we_q;
    assign halt        = halt_q;
    assign halt_code   = halt_code_q;
    assign instret     = instret_q;
    assign state_o     = state_q;
    assign inst_we     = ifu_rvalid && (state_q == S_FETCH);

endmodule
